// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Holds the data/register widths, the stack-pointer register index, the
// handshake FSM state type and the EX->MEM control bundle.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] SP_REG = 5'h1B;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_t;

  // Control bits travelling from execute into the memory stage and on to
  // write-back.
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_read;
    logic             mem_to_reg;
    logic             mem_src;
    logic             pop;
    logic [REG_W-1:0] dest_reg;
  } ex_ctrl_t;

  function automatic logic is_memop(input ex_ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory request/acknowledge sequencer with an ack timeout.
//
// state | meaning
// IDLE  | no access outstanding (an access may be acked in its first cycle)
// WAIT  | access outstanding, no ack yet, wait counter running
//
// Ports:
//   clk, rst_n - clock, async active-low reset
//   start      - stage holds a valid memory instruction
//   ack        - data-memory acknowledge
//   req        - request to data memory
//   done       - access acknowledged this cycle
//   timeout    - access abandoned this cycle (ACK_TIMEOUT wait cycles elapsed)
module mem_handshake
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done,
  output logic timeout
);

  localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

  hs_state_t  state;
  logic [7:0] wait_cnt;

  // The request is simply the registered stage contents, so it is held
  // steady until the stage is released and drops with the async reset.
  assign req     = start;
  assign done    = start && ack;
  // The counter would reach ACK_TIMEOUT on this edge.
  assign timeout = start && !ack && (state == WAIT) && (wait_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start && !ack) state <= WAIT;
        end
        WAIT: begin
          if (!start || ack || timeout) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the pipeline: EX/MEM register, data-memory handshake,
// registered write-back outputs and a combinational forwarding tap.
//
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid, *_in      - instruction and control bits from execute
//   EX_out              - ALU result / address when MemSrc_in=0
//   MemWrite_data       - store data
//   sp_in               - stack pointer / address when MemSrc_in=1
//   flush               - squash the held instruction
//   stall_out           - upstream must hold
//   dmem_*              - data-memory request/ack interface
//   wb_*                - registered write-back results
//   fwd_*               - forwarding view of the held instruction
//   mem_err             - one-cycle pulse after an ack timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic              pop_in,
  input  logic [REG_W-1:0]  DestReg_in,
  input  logic [DATA_W-1:0] EX_out,
  input  logic [DATA_W-1:0] MemWrite_data,
  input  logic [DATA_W-1:0] sp_in,
  input  logic              flush,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_pop,
  output logic [REG_W-1:0]  wb_DestReg,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_err
);

  ex_ctrl_t          in_ctrl;
  ex_ctrl_t          s_ctrl;
  logic              s_valid;
  logic              s_flushed;
  logic [DATA_W-1:0] s_ex;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_sp;

  logic memop;
  logic start;
  logic hs_done;
  logic hs_timeout;
  logic complete;
  logic squash;

  assign in_ctrl = '{
    reg_write:  RegWrite_in,
    mem_write:  MemWrite_in,
    mem_read:   MemRead_in,
    mem_to_reg: MemToReg_in,
    mem_src:    MemSrc_in,
    pop:        pop_in,
    dest_reg:   DestReg_in
  };

  assign memop     = is_memop(s_ctrl);
  assign start     = s_valid && memop;
  assign stall_out = start && !dmem_ack;

  mem_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ack    (dmem_ack),
    .req    (dmem_req),
    .done   (hs_done),
    .timeout(hs_timeout)
  );

  // Write wins when both read and write are set, which falls out of
  // driving dmem_we straight from the write bit.
  assign dmem_we    = s_ctrl.mem_write;
  assign dmem_addr  = s_ctrl.mem_src ? s_sp : s_ex;
  assign dmem_wdata = s_wdata;

  assign complete = s_valid && (!memop || hs_done || hs_timeout);
  // A flush seen while an access is outstanding is remembered so the
  // access still runs to ack/timeout but never writes back.
  assign squash   = flush || s_flushed;

  assign fwd_valid = s_valid && s_ctrl.reg_write && !s_ctrl.mem_to_reg;
  assign fwd_dest  = s_ctrl.dest_reg;
  assign fwd_data  = s_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid   <= 1'b0;
      s_flushed <= 1'b0;
      s_ctrl    <= '0;
      s_ex      <= '0;
      s_wdata   <= '0;
      s_sp      <= '0;
    end else if (!stall_out) begin
      s_valid   <= in_valid && !flush;
      s_flushed <= 1'b0;
      if (in_valid) begin
        s_ctrl  <= in_ctrl;
        s_ex    <= EX_out;
        s_wdata <= MemWrite_data;
        s_sp    <= sp_in;
      end
    end else if (hs_timeout) begin
      // Abandoned access frees the stage; upstream is taken next cycle.
      s_valid   <= 1'b0;
      s_flushed <= 1'b0;
    end else if (flush) begin
      s_flushed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_pop      <= 1'b0;
      wb_DestReg  <= '0;
      wb_data     <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= complete && !squash;
      mem_err  <= hs_timeout;
      if (complete && !squash) begin
        wb_RegWrite <= s_ctrl.reg_write && !hs_timeout;
        wb_pop      <= s_ctrl.pop && !hs_timeout;
        wb_DestReg  <= s_ctrl.dest_reg;
        wb_data     <= s_ctrl.mem_to_reg ? dmem_rdata : s_ex;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the CPU pipeline, directly downstream of the execute unit. Holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake for loads, stores, call, ret and pop. Stalls upstream while a memory access is outstanding. Produces registered write-back results plus a forwarding tap.

## Interface
- ACK_TIMEOUT, default 255: cycles an access waits for `dmem_ack` before it is aborted. Legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: execute stage presents an instruction this cycle.
- `RegWrite_in`, `MemWrite_in`, `MemRead_in`, `MemToReg_in`, `MemSrc_in`, `pop_in` input 1 each: control bits from the execute stage.
- `DestReg_in` input 5: destination register (already remapped to SP, 0x1B, for call/ret).
- `EX_out` input 32: ALU or load-immediate result; also the memory address when `MemSrc_in`=0.
- `MemWrite_data` input 32: store data (the PC for call).
- `sp_in` input 32: current stack pointer; the memory address when `MemSrc_in`=1.
- `flush` input 1: squash the held instruction.
- `stall_out` output 1: upstream must hold its outputs; `in_valid` is not accepted.
- `dmem_req`, `dmem_we` output 1 each; `dmem_addr`, `dmem_wdata` output 32 each; `dmem_rdata` input 32; `dmem_ack` input 1.
- `wb_valid`, `wb_RegWrite`, `wb_pop` output 1 each; `wb_DestReg` output 5; `wb_data` output 32.
- `fwd_valid` output 1, `fwd_dest` output 5, `fwd_data` output 32: combinational view of the held instruction, for forwarding into execute.
- `mem_err` output 1: one-cycle pulse when an access times out.

## Operation
- **Stage register S.** Holds a valid bit plus all `*_in` fields.
  - Loaded on the clock edge where `!stall_out`. S.valid takes `in_valid && !flush`.
  - `memop` = S.MemRead | S.MemWrite. When both are set, the write takes priority and the read is ignored.
- **FSM.**
  - IDLE: no access outstanding.
  - WAIT: access outstanding; S.valid && memop && no ack yet; the wait counter runs.
  - IDLE→WAIT: when S.valid && memop && !`dmem_ack`.
  - WAIT→IDLE: on `dmem_ack`, on timeout, or on reset.
- **Memory interface.**
  - `dmem_req` = S.valid && memop. It is held steady until acked.
  - `dmem_we` = S.MemWrite.
  - `dmem_addr` = S.MemSrc ? `sp_in` (sampled when S loads, then held) : S.EX_out.
  - `dmem_wdata` = S.MemWrite_data.
  - Address, write data and `dmem_we` must not change while `dmem_req` is high.
- **Completion.**
  - Non-memory instruction: completes the cycle S is occupied.
  - Memory instruction: completes the cycle `dmem_ack` is high.
  - `stall_out` = S.valid && memop && !`dmem_ack`.
- **Write-back registers.** Loaded on the completion edge:
  - `wb_valid`=1.
  - `wb_RegWrite`=S.RegWrite.
  - `wb_DestReg`=S.DestReg.
  - `wb_pop`=S.pop.
  - `wb_data`=S.MemToReg ? `dmem_rdata` : S.EX_out.
  - On any other edge, `wb_valid`=0 and the other wb fields hold their values.
- **Timeout.** An 8-bit counter increments each WAIT cycle. When it reaches ACK_TIMEOUT, the access is dropped and the stage completes with `wb_RegWrite`=0 and `wb_pop`=0. `mem_err` pulses for one cycle and the counter clears.
- **Flush.**
  - Held non-memory instruction: invalidated, no write-back.
  - Access outstanding: `dmem_req` is kept until ack or timeout, then completes with `wb_valid`=0.
  - A write already issued is never cancelled.
- **Forwarding.** `fwd_valid` = S.valid && S.RegWrite && !S.MemToReg; `fwd_dest`=S.DestReg; `fwd_data`=S.EX_out.

## Timing
- **Reset values.** S.valid=0, FSM=IDLE, counter=0. All outputs 0: `stall_out`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, all wb_*, fwd_*, `mem_err`.
- **Latency.** Accept edge E0. A non-memory instruction, or a memory op acked in its first cycle, shows `wb_valid` after E1. Each cycle of ack wait adds one.
- **Throughput.** One instruction per cycle with zero-wait memory.
- **Ack and accept.** `dmem_ack` is only meaningful while `dmem_req` is high. On the ack cycle, `stall_out` drops, so the next instruction is accepted on the same edge (back-to-back).
- **Flush and accept together.** On a cycle with `flush` and `in_valid` and no stall, S loads invalid.
- **Reset mid-access.** `dmem_req` deasserts immediately (asynchronous) and no write-back occurs.

## Structure
- **Shared package.** Constants `SP_REG`=5'h1B, `DATA_W`=32, `REG_W`=5; the FSM state enum (IDLE, WAIT); a struct bundling the EX→MEM control fields, reused by the execute-side and write-back-side blocks.
- **Sub-module.** One: `mem_handshake`, containing the FSM, wait counter and timeout. Its inputs are start/ack; its outputs are req/done/timeout.

## Test plan
- **ALU pass-through.** EX_out=0x12345678, RegWrite=1, DestReg=5 → after E1: wb_valid=1, wb_DestReg=5, wb_data=0x12345678; stall_out stays 0.
- **Load with 3 wait cycles.** MemRead=1, MemToReg=1, EX_out=0x100, ack on the 4th cycle with rdata=0xCAFEF00D → dmem_addr=0x100 held steady; stall_out high for 3 cycles; wb_data=0xCAFEF00D.
- **Call store.** MemWrite=1, MemSrc=1, sp_in=0x3FC, MemWrite_data=PC 0x40, DestReg=0x1B → dmem_we=1, addr=0x3FC, wdata=0x40.
- **Timeout.** ACK_TIMEOUT=4, load, ack never arrives → mem_err pulses once after 4 wait cycles; wb_RegWrite=0; pipeline resumes.
- **Flush during access.** Assert flush during a pending store → req is held until ack; no wb_valid; the next instruction is accepted on the ack edge.
- **Reset mid-access.** Drop rst_n while dmem_req=1 → all outputs are 0 immediately; after release, the stage is idle.
